gate_selftest_seq: RTL

Synthesizable self-test sequencer for 2-input combinational gate cells. It sits directly upstream and downstream of a gate under test: it drives the gate's `a`/`b` inputs through all four input combinations in order 00, 01, 10, 11, and samples the gate's `out` after a programmable settle time. Each sample is compared against a parameterized truth table. Results are reported as an error count, a per-vector failure mask and a pass flag, so the gate check runs in hardware rather than by reading a `$monitor` log.

---
 rtl/gate_selftest_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gate_selftest_seq.sv
// gate_selftest_seq
//
// Self-test sequencer for a 2-input combinational gate cell. Drives the
// gate's inputs through 00, 01, 10, 11 and holds each vector for
// SETTLE_CYCLES cycles. On the last cycle of each hold it samples the gate
// output and compares it with TRUTH_TABLE[{a,b}]. Results are reported as
// an error count, a per-vector failure mask and a pass flag.
//
// Parameters:
//   TRUTH_TABLE    expected gate output per vector, bit index = {a,b}
//                  (default 4'b1000 = AND)
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a run; honoured only in IDLE or DONE
//   dut_out    in   output of the gate under test
//   a, b       out  registered gate inputs
//   busy       out  run in progress
//   done       out  run complete, held until the next start
//   pass       out  valid with done; 1 = no mismatches
//   err_count  out  number of mismatching vectors (0..4)
//   fail_mask  out  bit i set = vector i mismatched
//
// Optional feature:
//   GATE_SELFTEST_STOP_ON_FAIL_EN  when defined, the first mismatch ends
//                                  the run at its sample edge.

module gate_selftest_seq #(
    parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    // The counter is loaded with SETTLE_CYCLES-1 and the sample happens on
    // the cycle it reads zero, so each vector spans exactly SETTLE_CYCLES edges.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t     state, state_d;
    logic [1:0] idx, idx_d;
    logic [3:0] cnt, cnt_d;
    logic       a_d, b_d, busy_d, done_d, pass_d;
    logic [2:0] err_d;
    logic [3:0] mask_d;
    logic       mismatch;
    logic       last_vec;

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        cnt_d    = cnt;
        a_d      = a;
        b_d      = b;
        busy_d   = busy;
        done_d   = done;
        pass_d   = pass;
        err_d    = err_count;
        mask_d   = fail_mask;
        mismatch = (dut_out != TRUTH_TABLE[idx]);
        last_vec = 1'b0;

        case (state)
            IDLE, DONE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start) begin
                    state_d = APPLY;
                    idx_d   = 2'd0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    mask_d  = '0;
                end
            end

            APPLY: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    if (mismatch) begin
                        err_d       = err_count + 3'd1;
                        mask_d[idx] = 1'b1;
                    end
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
                    last_vec = (idx == 2'd3) || mismatch;
`else
                    last_vec = (idx == 2'd3);
`endif
                    if (last_vec) begin
                        // pass is derived from the updated count so the
                        // final vector's result is included.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        idx_d   = 2'd0;
                        cnt_d   = 4'd0;
                    end else begin
                        idx_d      = idx + 2'd1;
                        cnt_d      = CNT_LOAD;
                        {a_d, b_d} = idx + 2'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            a         <= a_d;
            b         <= b_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            fail_mask <= mask_d;
        end
    end

endmodule
